// File: rtl/pe_array_feeder_pkg.sv
// rtl/pe_array_feeder_pkg.sv - shared sizes and FSM encoding for the PE array feeder
package pe_array_feeder_pkg;
  localparam int PE_N  = 8;
  localparam int PE_DW = 32;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/pe_array_feeder_feed_skew.sv
// rtl/pe_array_feeder_feed_skew.sv - per-lane delay lines turning aligned columns into the skewed lane bus
module feed_skew #(
  parameter int N    = 8,
  parameter int DW   = 32,
  parameter int SKEW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            adv,
  input  logic [N*DW-1:0] col,
  output logic [N*DW-1:0] lanes
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] q;
    assign lanes[i*DW +: DW] = q;

    if (SKEW == 0 || i == 0) begin : g_direct
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)            q <= '0;
        else if (clr || !adv) q <= '0;
        else                 q <= col[i*DW +: DW];
      end
    end else begin : g_delay
      // Lowest word of dl is the newest column entry; the top word is i steps old.
      logic [i*DW-1:0]     dl;
      logic [(i+1)*DW-1:0] sh;
      assign sh = {dl, col[i*DW +: DW]};

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dl <= '0;
          q  <= '0;
        end else if (clr || !adv) begin
          dl <= '0;
          q  <= '0;
        end else begin
          dl <= sh[i*DW-1:0];
          q  <= sh[(i+1)*DW-1 -: DW];
        end
      end
    end
  end

endmodule

// File: rtl/pe_array_feeder.sv
// rtl/pe_array_feeder.sv - buffers an NxN matrix from the host and streams it skewed into the PE array
module pe_array_feeder
  import pe_array_feeder_pkg::*;
#(
  parameter int N    = PE_N,
  parameter int DW   = PE_DW,
  parameter int SKEW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [N*DW-1:0] a_out,
  output logic            en_out,
  input  logic            fin,
  output logic            busy,
  output logic            done
);

  localparam int WW    = $clog2(N*N);
  localparam int SW    = $clog2(2*N);
  localparam int STEPS = (SKEW != 0) ? 2*N-1 : N;
  localparam logic [WW-1:0] W_LAST = WW'(N*N-1);
  localparam logic [SW-1:0] S_END  = SW'(STEPS);

  state_t          state;
  logic [WW-1:0]   wcnt;
  logic [SW-1:0]   s;
  logic            fin_lat;
  logic [DW-1:0]   mem [N*N];
  logic [N*DW-1:0] col;
  logic [SW-1:0]   step;
  logic            accept;
  logic            load_last;
  logic            adv;

  assign accept    = in_valid && in_ready && !flush;
  assign load_last = accept && (wcnt == W_LAST);
  // s holds the next step to emit; step 0 goes out on the edge that completes the load.
  assign step      = (state == ST_STREAM) ? s : '0;
  assign adv       = load_last || ((state == ST_STREAM) && (s != S_END));

  always_comb begin
    col = '0;
    if (step < SW'(N)) begin
      for (int i = 0; i < N; i++) begin
        col[i*DW +: DW] = mem[WW'(i*N) + WW'(step)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wcnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_LOAD;
      wcnt     <= '0;
      s        <= '0;
      fin_lat  <= 1'b0;
      in_ready <= 1'b0;
      en_out   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (flush) begin
      state    <= ST_LOAD;
      wcnt     <= '0;
      s        <= '0;
      fin_lat  <= 1'b0;
      in_ready <= 1'b1;
      en_out   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (load_last) begin
              wcnt     <= '0;
              s        <= SW'(1);
              state    <= ST_STREAM;
              in_ready <= 1'b0;
              en_out   <= 1'b1;
              busy     <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          fin_lat <= fin_lat | fin;
          if (s == S_END) begin
            state  <= ST_WAIT;
            en_out <= 1'b0;
            s      <= '0;
          end else begin
            s <= s + 1'b1;
          end
        end
        ST_WAIT: begin
          if (fin || fin_lat) begin
            state   <= ST_DONE;
            fin_lat <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        ST_DONE: begin
          state    <= ST_LOAD;
          in_ready <= 1'b1;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  feed_skew #(.N(N), .DW(DW), .SKEW(SKEW)) u_skew (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .adv   (adv),
    .col   (col),
    .lanes (a_out)
  );

endmodule

// File: tb/tb_pe_array_feeder.sv
// tb/tb_pe_array_feeder.sv - scoreboard bench for pe_array_feeder (SKEW=1 and SKEW=0 instances)
module tb_pe_array_feeder;
  localparam int N  = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic fin = 1'b0;
  logic sel = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic in_ready1, en1, busy1, done1;
  logic in_ready0, en0, busy0, done0;
  logic [N*DW-1:0] a1, a0;

  logic in_ready, en_out, busy, done;
  logic [N*DW-1:0] a_out;
  assign in_ready = sel ? in_ready0 : in_ready1;
  assign en_out   = sel ? en0 : en1;
  assign busy     = sel ? busy0 : busy1;
  assign done     = sel ? done0 : done1;
  assign a_out    = sel ? a0 : a1;

  pe_array_feeder #(.N(N), .DW(DW), .SKEW(1)) dut (
    .clk(clk), .rst(rst), .flush(flush & ~sel), .in_valid(in_valid & ~sel),
    .in_data(in_data), .in_ready(in_ready1), .a_out(a1), .en_out(en1),
    .fin(fin & ~sel), .busy(busy1), .done(done1)
  );

  pe_array_feeder #(.N(N), .DW(DW), .SKEW(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush & sel), .in_valid(in_valid & sel),
    .in_data(in_data), .in_ready(in_ready0), .a_out(a0), .en_out(en0),
    .fin(fin & sel), .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [N*DW-1:0] exp_q[$];
  logic [DW-1:0]   mat [N*N];
  logic [N*DW-1:0] seen [16];
  int en_cnt, done_cnt, done_c, ready_c, en_last, early_en;

  function automatic logic [N*DW-1:0] model_step(input int k, input bit skew);
    logic [N*DW-1:0] v;
    int c;
    v = '0;
    for (int i = 0; i < N; i++) begin
      c = skew ? k - i : k;
      if (c >= 0 && c < N) v[i*DW +: DW] = mat[i*N + c];
    end
    return v;
  endfunction

  task automatic push_expected(input bit skew);
    for (int k = 0; k < (skew ? 2*N-1 : N); k++) exp_q.push_back(model_step(k, skew));
  endtask

  task automatic load_words(input int count, input bit bp);
    int idx;
    int cyc;
    bit rdy;
    idx = 0;
    cyc = 0;
    early_en = 0;
    while (idx < count && cyc < 2000) begin
      rdy = in_ready;
      if (en_out) early_en++;
      in_data  = mat[idx];
      in_valid = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (in_valid && rdy) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != count) begin
      failures++;
      $display("FAIL load_count got=%0d exp=%0d", idx, count);
    end
  endtask

  task automatic stream_phase(input int fin_at, input int flush_at);
    int c;
    logic [N*DW-1:0] e;
    c = 0;
    en_cnt = 0; done_cnt = 0; done_c = -1; ready_c = -1; en_last = -1;
    while (c < 200) begin
      if (en_out) begin
        if (en_cnt < 16) seen[en_cnt] = a_out;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (a_out !== e) begin
          failures++;
          $display("FAIL stream_data step=%0d got=%h exp=%h", en_cnt, a_out, e);
        end
        en_cnt++;
        en_last = c;
      end else if (en_cnt > 0 && done_c < 0) begin
        checks++;
        if (a_out !== '0) begin
          failures++;
          $display("FAIL wait_a_out cyc=%0d got=%h exp=0", c, a_out);
        end
      end
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
        in_valid = 1'b0;
      end
      if (in_ready && ready_c < 0) ready_c = c;
      if (done_c >= 0 && c >= done_c + 1) break;
      fin   = (c == fin_at);
      flush = (c == flush_at);
      @(posedge clk); #1;
      fin   = 1'b0;
      flush = 1'b0;
      if (c == flush_at) break;
      c++;
    end
    if (flush_at < 0) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL stream_short left=%0d exp=0", exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (en_out !== 1'b0) begin failures++; $display("FAIL rst_en_out got=%b exp=0", en_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (a_out !== '0) begin failures++; $display("FAIL rst_a_out got=%h exp=0", a_out); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_skew();
    for (int i = 0; i < N*N; i++) mat[i] = DW'(i);
    push_expected(1'b1);
    load_words(64, 1'b0);
    checks++; if (early_en != 0) begin failures++; $display("FAIL skew_early_en got=%0d exp=0", early_en); end
    checks++; if ({en_out, busy, in_ready} !== 3'b110) begin failures++; $display("FAIL skew_start got=%b exp=110", {en_out, busy, in_ready}); end
    stream_phase(20, -1);
    checks++; if (en_cnt != 15) begin failures++; $display("FAIL skew_en_len got=%0d exp=15", en_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL skew_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (done_c != 21) begin failures++; $display("FAIL skew_done_cyc got=%0d exp=21", done_c); end
    checks++; if (ready_c != 22) begin failures++; $display("FAIL skew_ready_cyc got=%0d exp=22", ready_c); end
    checks++; if (seen[0] !== '0) begin failures++; $display("FAIL skew_step0 got=%h exp=0", seen[0]); end
    checks++; if (seen[1][0 +: DW] !== 32'd1 || seen[1][DW +: DW] !== 32'd8) begin failures++; $display("FAIL skew_step1 got=%h", seen[1]); end
    checks++; if (seen[7][0 +: DW] !== 32'd7 || seen[7][7*DW +: DW] !== 32'd56) begin failures++; $display("FAIL skew_step7 got=%h", seen[7]); end
    checks++; if (seen[14][7*DW +: DW] !== 32'd63 || seen[14][7*DW-1:0] !== '0) begin failures++; $display("FAIL skew_step14 got=%h", seen[14]); end
  endtask

  task automatic test_backpressure();
    void'($urandom(1));
    for (int i = 0; i < N*N; i++) mat[i] = DW'(i);
    push_expected(1'b1);
    load_words(64, 1'b1);
    checks++; if (early_en != 0) begin failures++; $display("FAIL bp_early_en got=%0d exp=0", early_en); end
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    stream_phase(20, -1);
    in_valid = 1'b0;
    checks++; if (en_cnt != 15) begin failures++; $display("FAIL bp_en_len got=%0d exp=15", en_cnt); end
    checks++; if (ready_c != 22 || done_c != 21) begin failures++; $display("FAIL bp_ready_low got=%0d/%0d exp=22/21", ready_c, done_c); end
  endtask

  task automatic test_early_fin();
    for (int i = 0; i < N*N; i++) mat[i] = DW'(i*3 + 7);
    push_expected(1'b1);
    load_words(64, 1'b0);
    stream_phase(3, -1);
    checks++; if (en_cnt != 15) begin failures++; $display("FAIL efin_en_len got=%0d exp=15", en_cnt); end
    checks++; if (done_c != 16) begin failures++; $display("FAIL efin_done_cyc got=%0d exp=16", done_c); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL efin_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < N*N; i++) mat[i] = DW'(i);
    push_expected(1'b1);
    load_words(64, 1'b0);
    stream_phase(-1, 5);
    exp_q.delete();
    checks++; if (en_cnt != 6) begin failures++; $display("FAIL flush_steps got=%0d exp=6", en_cnt); end
    checks++; if ({en_out, busy, in_ready} !== 3'b001) begin failures++; $display("FAIL flush_ctrl got=%b exp=001", {en_out, busy, in_ready}); end
    checks++; if (a_out !== '0) begin failures++; $display("FAIL flush_a_out got=%h exp=0", a_out); end
    for (int i = 0; i < N*N; i++) mat[i] = 32'hFFFF_FFFF;
    push_expected(1'b1);
    load_words(64, 1'b0);
    stream_phase(20, -1);
    checks++; if (en_cnt != 15 || done_cnt != 1) begin failures++; $display("FAIL flush_reload got=%0d/%0d exp=15/1", en_cnt, done_cnt); end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < N*N; i++) mat[i] = 32'h1000 + DW'(i);
    load_words(30, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++; if ({in_ready, en_out, busy, done} !== 4'b0000) begin failures++; $display("FAIL mrst_ctrl got=%b exp=0000", {in_ready, en_out, busy, done}); end
    checks++; if (a_out !== '0) begin failures++; $display("FAIL mrst_a_out got=%h exp=0", a_out); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N*N; i++) mat[i] = 32'h2000 + DW'(i);
    push_expected(1'b1);
    load_words(64, 1'b0);
    checks++; if (early_en != 0) begin failures++; $display("FAIL mrst_early_en got=%0d exp=0", early_en); end
    stream_phase(20, -1);
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL mrst_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_skew0();
    sel = 1'b1;
    for (int i = 0; i < N*N; i++) mat[i] = DW'(i);
    push_expected(1'b0);
    load_words(64, 1'b0);
    stream_phase(12, -1);
    checks++; if (en_cnt != 8) begin failures++; $display("FAIL sk0_en_len got=%0d exp=8", en_cnt); end
    checks++; if (done_c != 13 || done_cnt != 1) begin failures++; $display("FAIL sk0_done got=%0d/%0d exp=13/1", done_c, done_cnt); end
    checks++; if (seen[3][5*DW +: DW] !== 32'd43) begin failures++; $display("FAIL sk0_lane5_s3 got=%0d exp=43", seen[3][5*DW +: DW]); end
    sel = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_skew();
    test_backpressure();
    test_early_fin();
    test_flush();
    test_reset_mid_load();
    test_skew0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
